pipelined_barrel_shifter: RTL
=============================

# pipelined_barrel_shifter

Parametrised, pipelined successor to the combinational barrel shifter. It adds a rotate mode, valid/ready flow control and one register stage per shift-amount bit. Each accepted word is shifted left or right (logical or arithmetic) or rotated by `sa` positions, and emerges after a fixed latency. It sits on datapath streams where a full-width combinational shifter would limit clock frequency.

## Interface
- `DATA_LENGTH`, default 8: data width.
  - Must be a power of two, 4..64.
- `SA_WIDTH`, default `$clog2(DATA_LENGTH)`: width of the shift amount; derived, do not override.
- `clk` input, 1: the block's one clock; all logic is on the rising edge.
- `rst` input, 1: reset, synchronous and active-high.
- `in_valid` input, 1: `data_in` and the control inputs are valid.
- `in_ready` output, 1: the block accepts the input this cycle.
- `data_in` input, `DATA_LENGTH`: operand.
- `right` input, 1: 1 = shift or rotate right, 0 = left.
- `arith` input, 1: 1 = arithmetic, i.e. sign-fill on right shifts.
- `rotate` input, 1: 1 = rotate (effective only with `BARREL_SHIFTER_ROTATE_EN`).
- `sa` input, `SA_WIDTH`: shift amount, 0..`DATA_LENGTH`-1.
- `out_valid` output, 1: `data_out` and `zero` are valid.
- `out_ready` input, 1: the downstream side accepts the output.
- `data_out` output, `DATA_LENGTH`: result.
- `zero` output, 1: `data_out` is all zeros.

## Operation
- **Transfer rule:** a transfer occurs on a rising edge when valid and ready are both high (applies to input and output).
- **Pipeline structure:** `SA_WIDTH` register stages, S0..S(`SA_WIDTH`-1).
  - Stage k conditionally moves the word by 2^k, controlled by `sa[k]`.
  - The control bits and a stage valid bit travel with the data.
- **Modes**, with N = `DATA_LENGTH` and amount = `sa`:
  - `rotate`=1: circular rotate in direction `right`; `arith` is ignored.
  - `right`=0, `rotate`=0: zero-fill left shift; `arith` is ignored (arithmetic left equals logical left).
  - `right`=1, `arith`=0: zero-fill right shift.
  - `right`=1, `arith`=1: right shift filled with `data_in[N-1]`, the sign bit captured at input and carried through the pipeline.
  - `sa`=0: `data_out` = `data_in` in every mode.
- **Outputs:**
  - `zero` is registered with `data_out` and equals `~|data_out`.
  - Lost bits are discarded; no carry or overflow output.
- **Flow control** uses a global advance: `adv = ~out_valid | out_ready`.
  - All stages load from their predecessor when `adv` = 1 and hold when `adv` = 0.
  - `in_ready = adv`.
  - S0's valid bit loads `in_valid & in_ready`.
  - Bubbles advance in lockstep and are not collapsed.
  - `out_valid` is the last stage's valid bit.
- **Ordering:** strictly in order. No data is dropped or duplicated under any `out_ready` pattern.
- **Stall:**
  - With `out_valid`=1 and `out_ready`=0, `data_out`, `zero` and all stage contents hold stable.
  - `in_ready`=0 in that case.
- **Simultaneous events:** an accept and an output transfer on the same edge are both taken; throughput is 1 word per cycle.

## Timing
- **Latency:** `SA_WIDTH` cycles from input transfer to `out_valid` with no stall (2 for N=4, 3 for N=8).
- **Reset values** (after a `rst` edge):
  - `out_valid`=0, `data_out`=0, `zero`=1.
  - Every stage valid bit = 0.
  - `in_ready`=1, since it follows `adv`.
- **Reset mid-operation:** in-flight words are flushed and never appear on the output.
  - An input presented in the reset cycle is not accepted.
- **Stage data when invalid:** may update, but must not affect any valid word.

## Configuration
- **`BARREL_SHIFTER_ROTATE_EN` defined:** rotate mode as specified above.
- **Macro undefined:**
  - The `rotate` port remains and is ignored, treated as 0.
  - No wrap-around muxing is synthesised.
  - `right`/`arith` shifts behave identically to the defined build.

## Test plan
All scenarios use N=4, `data_in`=1010 and `out_ready`=1 unless stated.
- **Logical shifts:** sweep `sa` 0..3, left -> 1010, 0100, 1000, 0000.
  - Right logical -> 1010, 0101, 0010, 0001.
  - `zero`=1 only for left `sa`=3.
- **Arithmetic:** right `arith`=1, `sa` 1..3 -> 1101, 1110, 1111.
  - Left `arith`=1, `sa`=1 -> 0100.
- **Rotate** (macro on): right `sa`=1 -> 0101; left `sa`=3 -> 0101; `sa`=0 -> 1010.
  - Macro off: rotate right `sa`=1 -> 0101 (logical); left `sa`=3 -> 0000.
- **Throughput and latency:** a back-to-back stream of 8 words appears in order, one per cycle.
  - First `out_valid` exactly 2 cycles after the first accept.
- **Backpressure:** random `out_ready` with about 50% duty over 200 words.
  - Scoreboard matches a reference model.
  - `data_out` is stable while stalled.
  - `in_ready` = `~out_valid | out_ready` every cycle.
- **Reset mid-stream:** assert `rst` for 1 cycle with 2 words in flight.
  - `out_valid`=0, `data_out`=0 and `zero`=1 on the next cycle.
  - The flushed words never appear.
  - A new word accepted after reset emerges correctly after 2 cycles.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//
// Pipelined left/right logical/arithmetic shifter with optional rotate.
// The shift is split into SA_WIDTH register stages. Stage k moves the word
// by 2^k positions when sa[k] is set. The direction, the fill bit and the
// remaining shift-amount bits travel with the word from stage to stage.
//
// Flow control uses one global advance term, adv = ~out_valid | out_ready.
// Every stage loads from its predecessor when adv is high and holds when it
// is low. Bubbles move through the pipeline in lockstep and are not removed.
//
// Optional feature: define BARREL_SHIFTER_ROTATE_EN to enable rotate mode.
// Without it, the rotate input is ignored and no wrap-around muxing is built.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   data_in and the control inputs are valid
//   in_ready   the input is accepted this cycle (equal to adv)
//   data_in    operand
//   right      1 = shift/rotate right, 0 = left
//   arith      1 = sign-fill on right shifts
//   rotate     1 = rotate (only with BARREL_SHIFTER_ROTATE_EN)
//   sa         shift amount, 0..DATA_LENGTH-1
//   out_valid  data_out and zero are valid
//   out_ready  downstream accepts the output
//   data_out   result
//   zero       data_out is all zeros (registered with data_out)
module pipelined_barrel_shifter #(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned SA_WIDTH    = $clog2(DATA_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   right,
    input  logic                   arith,
    input  logic                   rotate,
    input  logic [SA_WIDTH-1:0]    sa,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   zero
);

    localparam int NumStages = int'(SA_WIDTH);

    // Moves a word by a fixed amount in the selected direction and mode.
`ifdef BARREL_SHIFTER_ROTATE_EN
    function automatic logic [DATA_LENGTH-1:0] stage_shift(
        input logic [DATA_LENGTH-1:0] d,
        input int unsigned            amt,
        input logic                   to_right,
        input logic                   fill,
        input logic                   rot
    );
        logic [DATA_LENGTH-1:0] fill_mask;
        fill_mask = fill ? ~({DATA_LENGTH{1'b1}} >> amt) : '0;
        if (rot) begin
            stage_shift = to_right ? ((d >> amt) | (d << (DATA_LENGTH - amt)))
                                   : ((d << amt) | (d >> (DATA_LENGTH - amt)));
        end else if (to_right) begin
            stage_shift = (d >> amt) | fill_mask;
        end else begin
            stage_shift = d << amt;
        end
    endfunction
`else
    function automatic logic [DATA_LENGTH-1:0] stage_shift(
        input logic [DATA_LENGTH-1:0] d,
        input int unsigned            amt,
        input logic                   to_right,
        input logic                   fill
    );
        logic [DATA_LENGTH-1:0] fill_mask;
        fill_mask = fill ? ~({DATA_LENGTH{1'b1}} >> amt) : '0;
        if (to_right) begin
            stage_shift = (d >> amt) | fill_mask;
        end else begin
            stage_shift = d << amt;
        end
    endfunction
`endif

    // Per-stage data and valid; the last entry drives the outputs.
    logic [DATA_LENGTH-1:0] data_q  [NumStages];
    logic                   valid_q [NumStages];
    logic                   zero_q;

    // Control travelling with the word. The last stage needs none of it,
    // so these arrays are one entry shorter than the data pipeline.
    logic                   right_q [NumStages-1];
    logic                   fill_q  [NumStages-1];
    logic [SA_WIDTH-1:0]    sa_q    [NumStages-1];
`ifdef BARREL_SHIFTER_ROTATE_EN
    logic                   rot_q   [NumStages-1];
`else
    logic                   unused_rotate;
    assign unused_rotate = rotate;
`endif

    logic [DATA_LENGTH-1:0] res_data [NumStages];
    logic                   adv;
    logic                   fill_in;
    logic                   unused_sa_bits;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[NumStages-1];
    assign data_out  = data_q[NumStages-1];
    assign zero      = zero_q;

    // Sign bit captured at the input; it only matters for arithmetic right shifts.
    assign fill_in = right & arith & data_in[DATA_LENGTH-1];

    always_comb begin
`ifdef BARREL_SHIFTER_ROTATE_EN
        res_data[0] = sa[0] ? stage_shift(data_in, 32'd1, right, fill_in, rotate) : data_in;
        for (int k = 1; k < NumStages; k++) begin
            res_data[k] = sa_q[k-1][k]
                ? stage_shift(data_q[k-1], 32'd1 << k, right_q[k-1], fill_q[k-1], rot_q[k-1])
                : data_q[k-1];
        end
`else
        res_data[0] = sa[0] ? stage_shift(data_in, 32'd1, right, fill_in) : data_in;
        for (int k = 1; k < NumStages; k++) begin
            res_data[k] = sa_q[k-1][k]
                ? stage_shift(data_q[k-1], 32'd1 << k, right_q[k-1], fill_q[k-1])
                : data_q[k-1];
        end
`endif
    end

    // Already-consumed low shift-amount bits are carried but never read.
    always_comb begin
        unused_sa_bits = 1'b0;
        for (int j = 0; j < NumStages - 1; j++) begin
            unused_sa_bits = unused_sa_bits ^ (^sa_q[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NumStages; k++) begin
                data_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end
            for (int j = 0; j < NumStages - 1; j++) begin
                right_q[j] <= 1'b0;
                fill_q[j]  <= 1'b0;
                sa_q[j]    <= '0;
`ifdef BARREL_SHIFTER_ROTATE_EN
                rot_q[j]   <= 1'b0;
`endif
            end
            zero_q <= 1'b1;
        end else if (adv) begin
            data_q[0]  <= res_data[0];
            valid_q[0] <= in_valid & adv;
            for (int k = 1; k < NumStages; k++) begin
                data_q[k]  <= res_data[k];
                valid_q[k] <= valid_q[k-1];
            end
            right_q[0] <= right;
            fill_q[0]  <= fill_in;
            sa_q[0]    <= sa;
`ifdef BARREL_SHIFTER_ROTATE_EN
            rot_q[0]   <= rotate;
`endif
            for (int j = 1; j < NumStages - 1; j++) begin
                right_q[j] <= right_q[j-1];
                fill_q[j]  <= fill_q[j-1];
                sa_q[j]    <= sa_q[j-1];
`ifdef BARREL_SHIFTER_ROTATE_EN
                rot_q[j]   <= rot_q[j-1];
`endif
            end
            zero_q <= ~|res_data[NumStages-1];
        end
    end

endmodule
